// File: rtl/ex_alu_stage_if.sv
// rtl/ex_alu_stage_if.sv - ID/EX-to-EX and EX-to-MEM handshake bundle for ex_alu_stage
interface ex_alu_stage_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [3:0]      alu_ctrl;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic [4:0]      rd_in;

  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            zero;
  logic [4:0]      rd_out;
  logic            illegal;

  modport master (
    output in_valid, alu_ctrl, op_a, op_b, rd_in, out_ready,
    input  in_ready, out_valid, result, zero, rd_out, illegal
  );

  modport slave (
    input  in_valid, alu_ctrl, op_a, op_b, rd_in, out_ready,
    output in_ready, out_valid, result, zero, rd_out, illegal
  );
endinterface

// File: rtl/ex_alu_stage.sv
// rtl/ex_alu_stage.sv - EX-stage ALU with a single-entry EX/MEM output register
// Flush beats everything; the illegal-op counter only survives until rst.
module ex_alu_stage #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  ex_alu_stage_if.slave    bus,
  output logic [CNT_W-1:0] illegal_cnt
);
  localparam int S = $clog2(XLEN);

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_AND = 4'b0010;
  localparam logic [3:0] OP_OR  = 4'b0011;
  localparam logic [3:0] OP_XOR = 4'b0100;
  localparam logic [3:0] OP_SLL = 4'b0101;
  localparam logic [3:0] OP_SRL = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_SRA = 4'b1000;
  localparam logic [3:0] OP_NOR = 4'b1001;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [XLEN-1:0]  alu_res;
  logic             alu_zero;
  logic             op_illegal;
  logic [S-1:0]     shamt;
  logic             accept;

  logic             out_valid_q;
  logic [XLEN-1:0]  result_q;
  logic             zero_q;
  logic [4:0]       rd_q;
  logic             illegal_q;
  logic [CNT_W-1:0] cnt_q;

  assign shamt = bus.op_b[S-1:0];

  always_comb begin
    alu_res    = '0;
    op_illegal = 1'b0;
    unique case (bus.alu_ctrl)
      OP_ADD: alu_res = bus.op_a + bus.op_b;
      OP_SUB: alu_res = bus.op_a - bus.op_b;
      OP_AND: alu_res = bus.op_a & bus.op_b;
      OP_OR:  alu_res = bus.op_a | bus.op_b;
      OP_XOR: alu_res = bus.op_a ^ bus.op_b;
      OP_SLL: alu_res = bus.op_a << shamt;
      OP_SRL: alu_res = bus.op_a >> shamt;
      OP_SRA: alu_res = $signed(bus.op_a) >>> shamt;
      OP_SLT: alu_res = {{(XLEN-1){1'b0}}, ($signed(bus.op_a) < $signed(bus.op_b))};
      OP_NOR: alu_res = ~(bus.op_a | bus.op_b);
      default: begin
        alu_res    = '0;
        op_illegal = 1'b1;
      end
    endcase
  end

  assign alu_zero = (alu_res == '0);

  // in_ready must not depend on in_valid or data, only on the output register state.
  assign bus.in_ready = !out_valid_q || bus.out_ready;
  assign accept       = bus.in_valid && bus.in_ready && !flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      result_q    <= '0;
      zero_q      <= 1'b1;
      rd_q        <= '0;
      illegal_q   <= 1'b0;
      cnt_q       <= '0;
    end else begin
      if (flush) begin
        out_valid_q <= 1'b0;
      end else if (accept) begin
        out_valid_q <= 1'b1;
      end else if (bus.out_ready) begin
        out_valid_q <= 1'b0;
      end

      // Data registers hold across drain and stall; only an accepted op reloads them.
      if (accept) begin
        result_q  <= alu_res;
        zero_q    <= alu_zero;
        rd_q      <= bus.rd_in;
        illegal_q <= op_illegal;
      end

      if (accept && op_illegal && (cnt_q != CNT_MAX)) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.zero      = zero_q;
  assign bus.rd_out    = rd_q;
  assign bus.illegal   = illegal_q;
  assign illegal_cnt   = cnt_q;
endmodule

// File: tb/tb_ex_alu_stage.sv
// tb/tb_ex_alu_stage.sv - scoreboard bench for ex_alu_stage (CNT_W=8 and CNT_W=2 instances)
module tb_ex_alu_stage;
  typedef struct {
    logic [31:0] res;
    logic        zero;
    logic [4:0]  rd;
    logic        ill;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       flush;
  logic [7:0] cnt_out;
  logic [1:0] cnt2_out;

  ex_alu_stage_if #(.XLEN(32)) bus ();
  ex_alu_stage_if #(.XLEN(32)) bus2 ();

  ex_alu_stage #(.XLEN(32), .CNT_W(8)) u_dut (
    .clk(clk), .rst(rst), .flush(flush), .bus(bus), .illegal_cnt(cnt_out)
  );

  ex_alu_stage #(.XLEN(32), .CNT_W(2)) u_dut2 (
    .clk(clk), .rst(rst), .flush(flush), .bus(bus2), .illegal_cnt(cnt2_out)
  );

  assign bus2.in_valid  = bus.in_valid;
  assign bus2.alu_ctrl  = bus.alu_ctrl;
  assign bus2.op_a      = bus.op_a;
  assign bus2.op_b      = bus.op_b;
  assign bus2.rd_in     = bus.rd_in;
  assign bus2.out_ready = bus.out_ready;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  logic mv;
  int   exp_cnt;
  int   exp_cnt2;
  logic started;
  logic after_rst;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference ALU: plain arithmetic on the op definitions.
  function automatic exp_t ref_alu(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                                   input logic [4:0] rd);
    exp_t        e;
    int unsigned sh;
    longint      prod;
    sh    = b % 32;
    e.ill = 1'b0;
    e.rd  = rd;
    case (c)
      4'd0: e.res = a + b;
      4'd1: e.res = a - b;
      4'd2: e.res = a & b;
      4'd3: e.res = a | b;
      4'd4: e.res = a ^ b;
      4'd5: begin
        prod  = longint'(a) * (longint'(1) << sh);
        e.res = prod[31:0];
      end
      4'd6: e.res = a >> sh;
      4'd8: e.res = (a >> sh) | (a[31] ? ~(32'hFFFF_FFFF >> sh) : 32'h0);
      4'd7: e.res = (int'(a) < int'(b)) ? 32'd1 : 32'd0;
      4'd9: e.res = ~(a | b);
      default: begin
        e.res = 32'h0;
        e.ill = 1'b1;
      end
    endcase
    e.zero = (e.res == 32'h0);
    return e;
  endfunction

  task automatic step(input logic v, input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                      input logic [4:0] rd, input logic ordy, input logic fl, input logic r);
    exp_t e;
    logic acc;
    bus.in_valid  = v;
    bus.alu_ctrl  = c;
    bus.op_a      = a;
    bus.op_b      = b;
    bus.rd_in     = rd;
    bus.out_ready = ordy;
    flush         = fl;
    rst           = r;
    e   = ref_alu(c, a, b, rd);
    acc = !r && !fl && v && (!mv || ordy);
    if (acc) sb.push_back(e);
    @(posedge clk);
    #1;
    if (r) begin
      mv       = 1'b0;
      exp_cnt  = 0;
      exp_cnt2 = 0;
    end else begin
      if (fl) mv = 1'b0;
      else if (acc) mv = 1'b1;
      else if (ordy) mv = 1'b0;
      if (acc && e.ill) begin
        if (exp_cnt < 255) exp_cnt++;
        if (exp_cnt2 < 3) exp_cnt2++;
      end
    end
  endtask

  task automatic op(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
    step(1'b1, c, a, b, rd, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic idle(input logic ordy);
    step(1'b0, 4'd0, $urandom, $urandom, 5'($urandom), ordy, 1'b0, 1'b0);
  endtask

  // Monitor: checks presented output against the scoreboard head every cycle.
  always @(negedge clk) begin
    if (started) begin
      chk("out_valid", 32'(bus.out_valid), 32'(mv));
      chk("in_ready", 32'(bus.in_ready), 32'(!mv || bus.out_ready));
      chk("illegal_cnt", 32'(cnt_out), exp_cnt);
      chk("illegal_cnt_w2", 32'(cnt2_out), exp_cnt2);
      if (after_rst) begin
        chk("rst_result", bus.result, 32'h0);
        chk("rst_zero", 32'(bus.zero), 32'd1);
        chk("rst_rd", 32'(bus.rd_out), 32'd0);
        chk("rst_illegal", 32'(bus.illegal), 32'd0);
      end
      if (mv) begin
        if (sb.size() == 0) begin
          chk("sb_nonempty", 32'(sb.size()), 32'd1);
        end else begin
          chk("result", bus.result, sb[0].res);
          chk("zero", 32'(bus.zero), 32'(sb[0].zero));
          chk("rd_out", 32'(bus.rd_out), 32'(sb[0].rd));
          chk("illegal", 32'(bus.illegal), 32'(sb[0].ill));
          if (rst || flush || bus.out_ready) void'(sb.pop_front());
        end
      end
      after_rst = rst;
    end
  end

  initial begin
    logic [31:0] a, b;
    started   = 1'b0;
    after_rst = 1'b0;
    mv        = 1'b0;
    exp_cnt   = 0;
    exp_cnt2  = 0;
    step(1'b0, 4'd0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b1);
    started = 1'b1;
    step(1'b0, 4'd0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b1);
    idle(1'b1);

    // Arithmetic and shift/compare corner cases
    op(4'd0, 32'hFFFF_FFFF, 32'h1, 5'd1);
    op(4'd1, 32'd5, 32'd7, 5'd2);
    op(4'd8, 32'h8000_0000, 32'h24, 5'd3);
    op(4'd6, 32'h8000_0000, 32'h24, 5'd4);
    op(4'd7, 32'hFFFF_FFFF, 32'h1, 5'd5);
    op(4'd9, 32'h0, 32'h0, 5'd6);
    op(4'd5, 32'h0000_0003, 32'hFFFF_FFE1, 5'd7);
    idle(1'b1);

    // Backpressure: hold for 3 cycles while upstream keeps offering
    op(4'd0, 32'd100, 32'd23, 5'd9);
    repeat (3) step(1'b1, 4'd4, $urandom, $urandom, 5'd10, 1'b0, 1'b0, 1'b0);
    idle(1'b1);

    // Flush with a held op and an incoming op, then accept rd=7
    op(4'd2, 32'hF0F0_F0F0, 32'hFF00_FF00, 5'd11);
    step(1'b1, 4'hF, 32'h1, 32'h2, 5'd12, 1'b0, 1'b0, 1'b0);
    step(1'b1, 4'hF, 32'h1, 32'h2, 5'd13, 1'b1, 1'b1, 1'b0);
    op(4'd3, 32'h1, 32'h2, 5'd7);
    idle(1'b1);

    // Illegal ops from a clean counter
    step(1'b0, 4'd0, 32'h0, 32'h0, 5'd0, 1'b1, 1'b0, 1'b1);
    repeat (3) op(4'hF, $urandom, $urandom, 5'd20);
    repeat (5) op(4'hA, $urandom, $urandom, 5'd21);
    idle(1'b1);
    step(1'b0, 4'd0, 32'h0, 32'h0, 5'd0, 1'b1, 1'b0, 1'b1);
    idle(1'b1);

    // Reset while stalled
    op(4'd0, 32'd1, 32'd2, 5'd22);
    idle(1'b0);
    step(1'b1, 4'd0, 32'd3, 32'd4, 5'd23, 1'b0, 1'b0, 1'b1);
    idle(1'b0);
    idle(1'b1);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      a = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
      b = ($urandom_range(0, 7) == 0) ? a : $urandom;
      step($urandom_range(0, 9) < 7, 4'($urandom), a, b, 5'($urandom),
           $urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0, $urandom_range(0, 99) == 0);
    end

    repeat (3) idle(1'b1);
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/ex_alu_stage.md
# ex_alu_stage

Execute-stage ALU with its EX/MEM output register for the 5-stage RISC-V pipeline. It consumes the 4-bit `alu_ctrl` code from the ALU control decoder and the two forwarded operands. It computes the result, then holds it in a single-entry output register with a valid/ready handshake, flush support and a saturating illegal-op counter. It sits between the ID/EX register (upstream) and the MEM stage (downstream).

## Interface
- `XLEN`, 32: operand/result width; must be a power of two ≥ 8.
- `CNT_W`, 8: width of the illegal-op counter.

- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  operation presented by ID/EX.
- `in_ready`  out  1  stage can accept this cycle.
- `alu_ctrl`  in  4  operation code from ALU control.
- `op_a`  in  XLEN  operand A (rs1 / forwarded).
- `op_b`  in  XLEN  operand B (rs2, immediate, or forwarded).
- `rd_in`  in  5  destination register tag, carried through.
- `flush`  in  1  kill the held and incoming operation (branch mispredict).
- `out_valid`  out  1  result register holds a live op.
- `out_ready`  in  1  MEM stage accepts the result.
- `result`  out  XLEN  registered ALU result.
- `zero`  out  1  registered (result == 0), for branch resolution.
- `rd_out`  out  5  registered destination tag.
- `illegal`  out  1  registered: the held op had an undefined `alu_ctrl`.
- `illegal_cnt`  out  CNT_W  saturating count of accepted undefined ops.

## Operation
- `alu_ctrl` codes and their results:
  - 0000 ADD: a+b.
  - 0001 SUB: a−b.
  - 0010 AND.
  - 0011 OR.
  - 0100 XOR.
  - 0101 SLL: a << b[S-1:0].
  - 0110 SRL: logical right shift by b[S-1:0].
  - 1000 SRA: arithmetic right shift by b[S-1:0].
  - 0111 SLT: signed a<b, giving {0…,1} or 0.
  - 1001 NOR: ~(a|b).
  - Any other code (1010–1111): result 0 and `illegal`=1.
- S = $clog2(XLEN). Upper bits of `op_b` are ignored for shifts.
- ADD/SUB wrap modulo 2^XLEN. No overflow flag.
- `zero` is computed from the combinational result and registered with it.
- Acceptance: `in_ready` = !out_valid || out_ready. An op is accepted when in_valid && in_ready && !flush.
- On acceptance, the next cycle has `result`, `zero`, `rd_out` and `illegal` loaded, and `out_valid`=1.
- Drain without a new op: out_valid && out_ready && !(accepted) → `out_valid`=0 next cycle. The data registers hold their last value.
- Stall: out_valid && !out_ready → all output registers hold, and `in_ready`=0.
- Flush has priority over everything. It forces `out_valid`=0 next cycle and blocks acceptance that cycle, regardless of `in_valid` or `out_ready`.
- `illegal_cnt` increments by 1 for each accepted op with an undefined code.
  - It saturates at 2^CNT_W−1.
  - It is not cleared by `flush`; only `rst` clears it.
  - Ops discarded by flush in the accept cycle are not counted.

## Timing
- Latency: 1 cycle from acceptance to `out_valid`.
- Throughput: 1 op/cycle while `out_ready`=1.
- `in_ready` is combinational from `out_valid` and `out_ready` only. No path from `in_valid` or the data inputs.
- Reset (synchronous):
  - `out_valid`=0, `result`=0, `zero`=1, `rd_out`=0, `illegal`=0, `illegal_cnt`=0.
  - `in_ready`=1 in the first cycle after reset.
- `rst` asserted mid-stall discards the held op. No handshake completes in the reset cycle.
- Same-cycle drain and accept (out_valid, out_ready, in_valid all 1): the old result leaves and the new one loads. No bubble.
- While `out_valid`=1 && `out_ready`=0, the outputs are stable cycle to cycle.

## Test plan
- Arithmetic: accept ADD with a=0xFFFFFFFF, b=1 → next cycle result=0, zero=1. Then SUB with a=5, b=7 → result=0xFFFFFFFE, zero=0.
- Shifts/compare:
  - SRA a=0x80000000, b=0x24 (shamt 4) → 0xF8000000.
  - SRL same inputs → 0x08000000.
  - SLT a=0xFFFFFFFF, b=1 → 1.
  - NOR a=0, b=0 → 0xFFFFFFFF.
- Backpressure: out_ready=0 for 3 cycles after an accepted op → in_ready=0, and result/rd_out are unchanged for 3 cycles. A back-to-back stream with out_ready=1 gives one result per cycle in order.
- Flush:
  - flush with in_valid=1 and out_valid=1 → next cycle out_valid=0, and the incoming op is not delivered or counted.
  - Next cycle, accepting rd_in=7 → rd_out=7.
- Illegal ops:
  - 3 accepted ops with alu_ctrl=1111 → illegal=1, result=0 each, illegal_cnt=3.
  - With CNT_W=2, 5 illegal ops → illegal_cnt=3.
  - rst → illegal_cnt=0.
- Reset mid-stall: hold an op with out_ready=0, assert rst for 1 cycle → out_valid=0, zero=1, in_ready=1 the following cycle.
